// File: rtl/ssd_pkg.sv
// ssd_pkg: scan-bus field positions, segment code table and FSM state type
// shared by the scan decoder and its segment decode sub-module.
package ssd_pkg;

   localparam int EN_BIT  = 12;
   localparam int AN_MSB  = 11;
   localparam int AN_LSB  = 8;
   localparam int DP_BIT  = 7;
   localparam int SEG_MSB = 6;
   localparam int SEG_LSB = 0;

   // segment code for nibble n lives at SEG_CODE[n] (abcdefg, active-high)
   localparam logic [15:0][6:0] SEG_CODE = {
      7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
      7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
   };

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      PUBLISH = 2'd2
   } ssd_state_e;

endpackage

// File: rtl/ssd_seg_decode.sv
// ssd_seg_decode: combinational map from a 7-bit segment pattern back to
// its hex nibble; hit is low when the pattern is not one of the 16 codes.
module ssd_seg_decode
   import ssd_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] nibble,
   output logic       hit
);

   // table search; codes are unique so at most one entry matches
   always_comb begin
      nibble = 4'h0;
      hit    = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (seg == SEG_CODE[i]) begin
            nibble = 4'(i);
            hit    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ssd_scan_decoder.sv
// ssd_scan_decoder: samples the multiplexed seven-segment scan bus, filters
// scan transitions, decodes each digit and republishes the 4-digit value.
// Build option: define SSD_DP_CAPTURE_EN to capture and publish per-digit dp;
// otherwise dp is tied low and the dp bit of the bus is ignored.
//
// state   | meaning
// IDLE    | no digit captured in the current frame (mask = 0)
// COLLECT | partial frame; waiting for remaining digits or timeout
// PUBLISH | one cycle: value_valid high, mask cleared
module ssd_scan_decoder
   import ssd_pkg::*;
#(
   parameter int STABLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 65535,
   parameter int TO_W           = 16
) (
   input  logic        sysclk,
   input  logic        reset,
   input  logic [12:0] ssd_in,
   output logic [15:0] value,
   output logic        value_valid,
   output logic [3:0]  digit_mask,
   output logic [3:0]  dp,
   output logic        seg_err,
   output logic        anode_err,
   output logic        frame_timeout
);

   localparam int               CNT_W    = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(STABLE_CYCLES - 2);
   localparam logic [TO_W-1:0]  TMR_LOAD = TO_W'(TIMEOUT_CYCLES);

   logic [12:0]      sync1_q, s_q, s_prev_q;
   logic [12:0]      pat_q, pat_d;
   logic [CNT_W-1:0] stab_cnt_q, stab_cnt_d;
   logic             accept_q, accept_d;

   // synchronizer, previous-sample register, stability counter, accepted pattern
   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         sync1_q    <= '0;
         s_q        <= '0;
         s_prev_q   <= '0;
         stab_cnt_q <= '0;
         accept_q   <= 1'b0;
         pat_q      <= '0;
      end else begin
         sync1_q    <= ssd_in;
         s_q        <= sync1_q;
         s_prev_q   <= s_q;
         stab_cnt_q <= stab_cnt_d;
         accept_q   <= accept_d;
         pat_q      <= pat_d;
      end
   end

   // acceptance fires only on the step into CNT_SAT, so a held pattern is taken once
   always_comb begin
      stab_cnt_d = '0;
      accept_d   = 1'b0;
      pat_d      = pat_q;
      if (s_q == s_prev_q) begin
         stab_cnt_d = (stab_cnt_q == CNT_SAT) ? CNT_SAT : stab_cnt_q + 1'b1;
         if (stab_cnt_q == CNT_PRE) begin
            accept_d = 1'b1;
            pat_d    = s_q;
         end
      end
   end

   logic [3:0] an;
   logic [3:0] seg_nib;
   logic       seg_hit, blank, an_onehot, capture;

   assign an = pat_q[AN_MSB:AN_LSB];

   ssd_seg_decode u_seg_decode (
      .seg    (pat_q[SEG_MSB:SEG_LSB]),
      .nibble (seg_nib),
      .hit    (seg_hit)
   );

   // classify the accepted pattern; a bad anode masks any segment error
   always_comb begin
      blank     = !pat_q[EN_BIT] || (an == 4'b0000);
      an_onehot = ((an & (an - 4'd1)) == 4'b0000);
      capture   = accept_q && !blank && an_onehot && seg_hit;
      anode_err = accept_q && !blank && !an_onehot;
      seg_err   = accept_q && !blank && an_onehot && !seg_hit;
   end

   ssd_state_e      state_q, state_d;
   logic [3:0]      mask_q, mask_d;
   logic [15:0]     shadow_q, shadow_d;
   logic [15:0]     value_q, value_d;
   logic [TO_W-1:0] tmr_q, tmr_d;
`ifdef SSD_DP_CAPTURE_EN
   logic [3:0]      shadow_dp_q, shadow_dp_d;
   logic [3:0]      dp_q, dp_d;
`endif

   // frame state, shadow digits, published value and timeout down-counter
   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         mask_q      <= '0;
         shadow_q    <= '0;
         value_q     <= '0;
         tmr_q       <= '0;
`ifdef SSD_DP_CAPTURE_EN
         shadow_dp_q <= '0;
         dp_q        <= '0;
`endif
      end else begin
         state_q     <= state_d;
         mask_q      <= mask_d;
         shadow_q    <= shadow_d;
         value_q     <= value_d;
         tmr_q       <= tmr_d;
`ifdef SSD_DP_CAPTURE_EN
         shadow_dp_q <= shadow_dp_d;
         dp_q        <= dp_d;
`endif
      end
   end

   // next-state: value is loaded on entry to PUBLISH so it is stable while value_valid is high
   always_comb begin
      state_d       = state_q;
      mask_d        = mask_q;
      shadow_d      = shadow_q;
      value_d       = value_q;
      tmr_d         = tmr_q;
      value_valid   = 1'b0;
      frame_timeout = 1'b0;
`ifdef SSD_DP_CAPTURE_EN
      shadow_dp_d   = shadow_dp_q;
      dp_d          = dp_q;
`endif
      if (capture) begin
         for (int i = 0; i < 4; i++) begin
            if (an[i]) begin
               shadow_d[4*i +: 4] = seg_nib;
`ifdef SSD_DP_CAPTURE_EN
               shadow_dp_d[i]     = pat_q[DP_BIT];
`endif
            end
         end
      end
      case (state_q)
         IDLE: begin
            if (capture) begin
               mask_d  = mask_q | an;
               tmr_d   = TMR_LOAD;
               state_d = COLLECT;
            end
         end
         COLLECT: begin
            if (mask_q == 4'b1111) begin
               value_d = shadow_q;
`ifdef SSD_DP_CAPTURE_EN
               dp_d    = shadow_dp_q;
`endif
               state_d = PUBLISH;
            end else if (capture) begin
               mask_d = mask_q | an;
               tmr_d  = TMR_LOAD;
            end else if (tmr_q == '0) begin
               frame_timeout = 1'b1;
               mask_d        = '0;
               state_d       = IDLE;
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         PUBLISH: begin
            value_valid = 1'b1;
            if (capture) begin
               mask_d  = an;
               tmr_d   = TMR_LOAD;
               state_d = COLLECT;
            end else begin
               mask_d  = '0;
               state_d = IDLE;
            end
         end
         default: begin
            mask_d  = '0;
            state_d = IDLE;
         end
      endcase
   end

   assign value      = value_q;
   assign digit_mask = mask_q;
`ifdef SSD_DP_CAPTURE_EN
   assign dp         = dp_q;
`else
   logic unused_dp;
   assign unused_dp  = pat_q[DP_BIT];
   assign dp         = 4'b0000;
`endif

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// tb_ssd_scan_decoder: directed scenarios plus a randomized pattern stream
// checked against a pattern-level model of the scan decoder.
module tb_ssd_scan_decoder;

   localparam int STABLE = 4;
   localparam int TMO    = 100;
`ifdef SSD_DP_CAPTURE_EN
   localparam bit DP_ON = 1'b1;
`else
   localparam bit DP_ON = 1'b0;
`endif

   logic        sysclk = 1'b0;
   logic        reset  = 1'b0;
   logic [12:0] ssd_in = '0;
   logic [15:0] value;
   logic        value_valid;
   logic [3:0]  digit_mask;
   logic [3:0]  dp;
   logic        seg_err, anode_err, frame_timeout;

   ssd_scan_decoder #(
      .STABLE_CYCLES  (STABLE),
      .TIMEOUT_CYCLES (TMO),
      .TO_W           (16)
   ) dut (
      .sysclk        (sysclk),
      .reset         (reset),
      .ssd_in        (ssd_in),
      .value         (value),
      .value_valid   (value_valid),
      .digit_mask    (digit_mask),
      .dp            (dp),
      .seg_err       (seg_err),
      .anode_err     (anode_err),
      .frame_timeout (frame_timeout)
   );

   always #5 sysclk = ~sysclk;

   logic [6:0] seg_tbl [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

   int n_checks = 0;
   int n_pass   = 0;
   int n_valid  = 0;
   int n_seg    = 0;
   int n_an     = 0;
   int n_to     = 0;
   logic [19:0] obs_q[$];

   always @(negedge sysclk) begin
      if (value_valid) begin
         n_valid++;
         obs_q.push_back({dp, value});
      end
      if (seg_err)       n_seg++;
      if (anode_err)     n_an++;
      if (frame_timeout) n_to++;
   end

   function automatic logic [12:0] dig(input int idx, input int nib, input bit dpv);
      logic [3:0] a;
      a = 4'(1 << idx);
      return {1'b1, a, dpv, seg_tbl[nib]};
   endfunction

   // 0 blank, 1 bad anode, 2 bad segments, 3 valid digit
   function automatic int classify(input logic [12:0] p, output int idx, output int nib);
      logic [3:0] a;
      idx = 0;
      nib = 0;
      a   = p[11:8];
      if (!p[12] || a == 4'b0000) return 0;
      if ($countones(a) != 1) return 1;
      for (int i = 0; i < 4; i++) if (a[i]) idx = i;
      for (int j = 0; j < 16; j++) begin
         if (p[6:0] == seg_tbl[j]) begin
            nib = j;
            return 3;
         end
      end
      return 2;
   endfunction

   task automatic hold(input logic [12:0] p, input int n);
      ssd_in = p;
      repeat (n) @(posedge sysclk);
      #1;
   endtask

   task automatic do_reset();
      ssd_in = '0;
      reset  = 1'b0;
      repeat (2) @(posedge sysclk);
      #1;
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset  = 1'b0;
      ssd_in = dig(0, 5, 1'b1);
      #3;
      n_checks++; if (value !== 16'h0000) $display("FAIL reset_value: got %h want 0000", value); else n_pass++;
      n_checks++; if (digit_mask !== 4'b0000) $display("FAIL reset_mask: got %b want 0000", digit_mask); else n_pass++;
      n_checks++; if (dp !== 4'b0000) $display("FAIL reset_dp: got %b want 0000", dp); else n_pass++;
      n_checks++;
      if ({value_valid, seg_err, anode_err, frame_timeout} !== 4'b0000)
         $display("FAIL reset_pulses: got %b want 0000", {value_valid, seg_err, anode_err, frame_timeout});
      else n_pass++;
      do_reset();
   endtask

   task automatic test_frame_decode();
      int v0, q0, lat;
      bit found;
      do_reset();
      v0 = n_valid;
      q0 = obs_q.size();
      hold(13'b1_0001_0_1111110, 8);
      hold(13'b1_0010_0_1111110, 8);
      hold(13'b1_0100_0_1101101, 8);
      n_checks++; if (digit_mask !== 4'b0111) $display("FAIL frame_partial_mask: got %b want 0111", digit_mask); else n_pass++;
      ssd_in = 13'b1_1000_0_1101101;
      found  = 1'b0;
      lat    = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge sysclk);
         if (value_valid) begin
            found = 1'b1;
            break;
         end
         lat++;
      end
      // 2 sync + STABLE to acceptance, then mask register and PUBLISH
      n_checks++;
      if (!found || lat != STABLE + 4) $display("FAIL frame_latency: got %0d (seen %0d) want %0d", lat, found, STABLE + 4);
      else n_pass++;
      repeat (10) @(posedge sysclk);
      #1;
      n_checks++; if (n_valid - v0 != 1) $display("FAIL frame_valid_count: got %0d want 1", n_valid - v0); else n_pass++;
      n_checks++; if (value !== 16'h2200) $display("FAIL frame_value: got %h want 2200", value); else n_pass++;
      n_checks++; if (dp !== 4'b0000) $display("FAIL frame_dp: got %b want 0000", dp); else n_pass++;
      n_checks++;
      if (obs_q.size() <= q0 || obs_q[q0] !== 20'h02200)
         $display("FAIL frame_pulse_value: got %h want 02200", (obs_q.size() > q0) ? obs_q[q0] : 20'hxxxxx);
      else n_pass++;
      n_checks++; if (digit_mask !== 4'b0000) $display("FAIL frame_mask_cleared: got %b want 0000", digit_mask); else n_pass++;
   endtask

   task automatic test_glitch();
      int v0, s0, a0;
      do_reset();
      v0 = n_valid; s0 = n_seg; a0 = n_an;
      hold(13'b1_0001_0_1111110, 8);
      hold(13'b1_0010_0_1111110, 8);
      hold(13'b1_0010_0_0110000, 1);
      hold(13'b1_0100_0_1101101, 8);
      hold(13'b1_0010_0_0110000, STABLE - 1);
      hold(13'b1_1000_0_1101101, STABLE);
      hold(13'h0000, 12);
      n_checks++; if (n_valid - v0 != 1) $display("FAIL glitch_valid_count: got %0d want 1", n_valid - v0); else n_pass++;
      n_checks++; if (value !== 16'h2200) $display("FAIL glitch_value: got %h want 2200", value); else n_pass++;
      n_checks++;
      if (n_seg != s0 || n_an != a0) $display("FAIL glitch_errors: got seg %0d an %0d want 0 0", n_seg - s0, n_an - a0);
      else n_pass++;
   endtask

   task automatic test_bad_segments();
      int v0, s0;
      do_reset();
      v0 = n_valid; s0 = n_seg;
      hold(dig(0, 1, 1'b0), 8);
      hold(13'b1_0010_0_0000001, 8);
      n_checks++; if (n_seg - s0 != 1) $display("FAIL badseg_pulses: got %0d want 1", n_seg - s0); else n_pass++;
      n_checks++; if (digit_mask !== 4'b0001) $display("FAIL badseg_mask: got %b want 0001", digit_mask); else n_pass++;
      hold(dig(2, 3, 1'b0), 8);
      hold(dig(3, 4, 1'b0), 8);
      n_checks++; if (n_valid != v0) $display("FAIL badseg_early_valid: got %0d want 0", n_valid - v0); else n_pass++;
      n_checks++; if (digit_mask !== 4'b1101) $display("FAIL badseg_mask2: got %b want 1101", digit_mask); else n_pass++;
      hold(dig(1, 5, 1'b0), 8);
      hold(13'h0000, 6);
      n_checks++; if (n_valid - v0 != 1) $display("FAIL badseg_valid_count: got %0d want 1", n_valid - v0); else n_pass++;
      n_checks++; if (value !== 16'h4351) $display("FAIL badseg_value: got %h want 4351", value); else n_pass++;
   endtask

   task automatic test_bad_anode();
      int s0, a0;
      do_reset();
      s0 = n_seg; a0 = n_an;
      hold(dig(0, 7, 1'b0), 8);
      hold(13'b1_0011_0_1111110, 8);
      n_checks++; if (n_an - a0 != 1) $display("FAIL badan_pulses: got %0d want 1", n_an - a0); else n_pass++;
      n_checks++; if (digit_mask !== 4'b0001) $display("FAIL badan_mask: got %b want 0001", digit_mask); else n_pass++;
      hold(13'b0_0100_0_1111110, 8);
      hold(13'b1_0000_0_0000001, 8);
      n_checks++;
      if (n_an - a0 != 1 || n_seg != s0) $display("FAIL blank_errors: got an %0d seg %0d want 1 0", n_an - a0, n_seg - s0);
      else n_pass++;
      n_checks++; if (digit_mask !== 4'b0001) $display("FAIL blank_mask: got %b want 0001", digit_mask); else n_pass++;
   endtask

   task automatic test_timeout();
      int v0, t0, lat;
      bit found;
      do_reset();
      hold(dig(0, 10, 1'b0), 8);
      hold(dig(1, 11, 1'b0), 8);
      hold(dig(2, 12, 1'b0), 8);
      hold(dig(3, 13, 1'b0), 8);
      hold(13'h0000, 10);
      v0 = n_valid; t0 = n_to;
      hold(dig(0, 1, 1'b0), 8);
      hold(dig(1, 2, 1'b0), 8);
      ssd_in = dig(2, 3, 1'b0);
      found  = 1'b0;
      lat    = 0;
      for (int k = 0; k < 300; k++) begin
         @(negedge sysclk);
         if (frame_timeout) begin
            found = 1'b1;
            break;
         end
         if (k == 8) ssd_in = '0;
         lat++;
      end
      // last capture lands STABLE+2 cycles after the drive; TMO cycles later the frame is dropped
      n_checks++;
      if (!found || lat < TMO + STABLE + 2 || lat > TMO + STABLE + 4)
         $display("FAIL timeout_latency: got %0d (seen %0d) want %0d..%0d", lat, found, TMO + STABLE + 2, TMO + STABLE + 4);
      else n_pass++;
      repeat (3) @(posedge sysclk);
      #1;
      n_checks++; if (digit_mask !== 4'b0000) $display("FAIL timeout_mask: got %b want 0000", digit_mask); else n_pass++;
      n_checks++; if (value !== 16'hDCBA) $display("FAIL timeout_value: got %h want dcba", value); else n_pass++;
      n_checks++; if (n_valid != v0) $display("FAIL timeout_no_valid: got %0d want 0", n_valid - v0); else n_pass++;
      n_checks++; if (n_to - t0 != 1) $display("FAIL timeout_pulses: got %0d want 1", n_to - t0); else n_pass++;
      hold(dig(0, 4, 1'b0), 8);
      hold(dig(1, 5, 1'b0), 8);
      hold(dig(2, 6, 1'b0), 8);
      hold(dig(3, 7, 1'b0), 8);
      hold(13'h0000, 6);
      n_checks++; if (value !== 16'h7654) $display("FAIL timeout_recover_value: got %h want 7654", value); else n_pass++;
   endtask

   task automatic test_reset_mid_frame();
      int v0;
      logic [3:0] dp_exp;
      do_reset();
      hold(dig(0, 1, 1'b1), 8);
      hold(dig(1, 2, 1'b0), 8);
      hold(dig(2, 3, 1'b0), 8);
      hold(dig(3, 4, 1'b0), 8);
      hold(13'h0000, 6);
      dp_exp = DP_ON ? 4'b0001 : 4'b0000;
      n_checks++;
      if (value !== 16'h4321 || dp !== dp_exp) $display("FAIL rst_pre_frame: got %h/%b want 4321/%b", value, dp, dp_exp);
      else n_pass++;
      hold(dig(0, 9, 1'b0), 8);
      hold(dig(1, 8, 1'b0), 8);
      hold(dig(2, 7, 1'b0), 8);
      v0     = n_valid;
      ssd_in = '0;
      reset  = 1'b0;
      #1;
      n_checks++;
      if (value !== 16'h0000 || digit_mask !== 4'b0000 || dp !== 4'b0000)
         $display("FAIL rst_async_clear: got %h/%b/%b want 0000/0000/0000", value, digit_mask, dp);
      else n_pass++;
      repeat (2) @(posedge sysclk);
      #1;
      reset = 1'b1;
      hold(13'h0000, 20);
      n_checks++; if (n_valid != v0) $display("FAIL rst_no_valid: got %0d want 0", n_valid - v0); else n_pass++;
      hold(dig(0, 6, 1'b0), 8);
      hold(dig(1, 7, 1'b0), 8);
      hold(dig(2, 8, 1'b0), 8);
      hold(dig(3, 9, 1'b1), 8);
      hold(13'h0000, 6);
      dp_exp = DP_ON ? 4'b1000 : 4'b0000;
      n_checks++; if (value !== 16'h9876) $display("FAIL rst_next_value: got %h want 9876", value); else n_pass++;
      n_checks++; if (dp !== dp_exp) $display("FAIL rst_next_dp: got %b want %b", dp, dp_exp); else n_pass++;
   endtask

   task automatic test_random();
      logic [12:0] p, prev;
      logic [3:0]  m_mask, m_dp, a;
      logic [15:0] m_shadow;
      logic [19:0] exp_q[$];
      int q0, s0, a0, t0, e_seg, e_an, run, kind, idx, nib, r, n_hold, n_obs;
      bit glitch;
      do_reset();
      q0 = obs_q.size(); s0 = n_seg; a0 = n_an; t0 = n_to;
      m_mask = '0; m_dp = '0; m_shadow = '0;
      e_seg = 0; e_an = 0; run = 0;
      prev = '0;
      for (int n = 0; n < 120; n++) begin
         r      = (run >= 4) ? 0 : $urandom_range(0, 9);
         glitch = (r == 9);
         do begin
            if (r <= 5) begin
               p = dig($urandom_range(0, 3), $urandom_range(0, 15), 1'($urandom_range(0, 1)));
            end else if (r == 6) begin
               do a = 4'($urandom_range(0, 15)); while ($countones(a) < 2);
               p = {1'b1, a, 8'($urandom_range(0, 255))};
            end else if (r == 7) begin
               p = {1'b1, 4'(1 << $urandom_range(0, 3)), 8'($urandom_range(0, 255))};
            end else if (r == 8) begin
               p = ($urandom_range(0, 1) == 0) ? {1'b0, 12'($urandom_range(0, 4095))}
                                               : {5'b1_0000, 8'($urandom_range(0, 255))};
            end else begin
               p = 13'($urandom_range(0, 8191));
            end
         end while (p == prev);
         n_hold = glitch ? $urandom_range(1, STABLE - 1) : $urandom_range(STABLE, 10);
         hold(p, n_hold);
         prev = p;
         if (glitch) begin
            run++;
         end else begin
            kind = classify(p, idx, nib);
            if (kind == 3) begin
               run = 0;
               m_shadow[4*idx +: 4] = 4'(nib);
               m_dp[idx]            = p[7];
               m_mask[idx]          = 1'b1;
               if (m_mask == 4'b1111) begin
                  exp_q.push_back({DP_ON ? m_dp : 4'b0000, m_shadow});
                  m_mask = '0;
               end
            end else begin
               run++;
               if (kind == 1) e_an++;
               if (kind == 2) e_seg++;
            end
         end
      end
      repeat (20) @(posedge sysclk);
      #1;
      n_obs = obs_q.size() - q0;
      n_checks++; if (n_obs != exp_q.size()) $display("FAIL rand_frames: got %0d want %0d", n_obs, exp_q.size()); else n_pass++;
      for (int i = 0; i < exp_q.size() && i < n_obs; i++) begin
         n_checks++;
         if (obs_q[q0 + i] !== exp_q[i]) $display("FAIL rand_frame_%0d: got %h want %h", i, obs_q[q0 + i], exp_q[i]);
         else n_pass++;
      end
      n_checks++; if (n_seg - s0 != e_seg) $display("FAIL rand_seg_err: got %0d want %0d", n_seg - s0, e_seg); else n_pass++;
      n_checks++; if (n_an - a0 != e_an) $display("FAIL rand_anode_err: got %0d want %0d", n_an - a0, e_an); else n_pass++;
      n_checks++; if (n_to != t0) $display("FAIL rand_timeout: got %0d want 0", n_to - t0); else n_pass++;
      n_checks++; if (digit_mask !== m_mask) $display("FAIL rand_mask: got %b want %b", digit_mask, m_mask); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_frame_decode();
      test_glitch();
      test_bad_segments();
      test_bad_anode();
      test_timeout();
      test_reset_mid_frame();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
